p_dispatch: RTL and testbench
=============================

Name: p_dispatch

Overview:
Priority dispatcher for the hardware scheduler: the distribution-side counterpart of the priority selector. It accepts one task per cycle on a valid/ready input and routes it to the lowest-index free, enabled execution slot (slot 0 = highest priority). It tracks per-slot busy state until each slot reports completion. It sits between the task queue and the N execution units.

Parameters:
N, 8, number of execution slots (2..16)
TAG_W, 8, task tag width in bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
task_valid  input  1  incoming task present
task_tag  input  TAG_W  incoming task identifier
task_ready  output  1  dispatcher can accept this cycle (combinational)
slot_en  input  N  per-slot enable mask; 0 = slot excluded from allocation
slot_done  input  N  per-slot completion pulse; frees the slot
slot_valid  output  N  one-hot dispatch pulse, registered, 1 cycle wide
slot_tag  output  TAG_W  tag of dispatched task, valid while slot_valid != 0
busy  output  N  registered per-slot busy state
err_done  output  1  sticky: slot_done seen on a non-busy slot

Behaviour:
- Reset (rst_n=0 at clk edge): busy=0, slot_valid=0, slot_tag=0, err_done=0. Reset wins over all other inputs in that cycle; any in-flight dispatch is dropped.
- free = ~busy & slot_en, computed from registered busy. slot_done is not bypassed: a slot freed by done in cycle t is allocatable from cycle t+1.
- task_ready = |free (combinational, never depends on task_valid).
- Accept = task_valid & task_ready. Target = lowest index i with free[i]=1.
- On accept at edge t: slot_valid <= one-hot(target), slot_tag <= task_tag, busy[target] <= 1. Latency accept->slot_valid: 1 cycle. Throughput: 1 task/cycle while free slots remain.
- No accept: slot_valid <= 0. slot_tag holds its last value.
- Done handling at each edge: busy[i] <= 0 where slot_done[i]=1 and busy[i]=1. slot_done[i] on non-busy slot: ignored for busy, err_done <= 1 (sticky until reset).
- Simultaneous done on slot j and dispatch to slot k: both applied (k != j is guaranteed, since k is not busy). A done for slot j alongside a spurious done elsewhere still frees j.
- Deasserting slot_en[i] while busy[i]=1 does not clear busy; the slot finishes normally and is then excluded.
- All slots busy or disabled: task_ready=0, task must hold (task_valid/task_tag stable is the upstream's obligation).
- Two-state FSM per slot: FREE -> BUSY on dispatch; BUSY -> FREE on slot_done.

Optional Feature:
Macro P_DISPATCH_STATS_EN. When defined, adds outputs disp_cnt (32 bits) and stall_cnt (32 bits), both reset to 0. disp_cnt increments per accept. stall_cnt increments each cycle with task_valid=1 and task_ready=0. Both counters saturate at all-ones. When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, slot_en=8'hFF, single task tag 8'h3C -> task_ready=1; next cycle slot_valid=8'h01, slot_tag=8'h3C, busy=8'h01.
- 8 back-to-back tasks, tags 0..7, no done -> slot_valid walks 01,02,04,...,80 on consecutive cycles; then task_ready=0, busy=8'hFF.
- busy=8'hFF, slot_done=8'h08 at cycle t with task_valid=1 -> task_ready=0 at t, 1 at t+1; dispatch to slot 3 (slot_valid=8'h08) at t+2.
- slot_en=8'hF0, busy=0, task valid -> dispatch to slot 4 (slot_valid=8'h10); slots 0..3 never selected.
- slot_done=8'h02 with busy=0 -> err_done=1 next cycle and stays 1; busy unchanged; cleared only by rst_n=0.
- Reset asserted in the same cycle as an accept -> slot_valid=0, busy=0 next cycle. With P_DISPATCH_STATS_EN, 3 accepts plus 2 stalled cycles -> disp_cnt=3, stall_cnt=2.

Source files
------------

// File: rtl/p_dispatch.sv
// p_dispatch: priority dispatcher for the hardware scheduler.
// Accepts one task per cycle on a valid/ready input and routes it to the
// lowest-index slot that is both free and enabled (slot 0 = highest priority).
// Each slot is a two-state FREE/BUSY machine. A dispatch moves the slot to
// BUSY. A slot_done pulse moves it back to FREE.
// Optional macro P_DISPATCH_STATS_EN adds the saturating counters
// disp_cnt and stall_cnt.
module p_dispatch #(
  parameter int N     = 8,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             task_valid,
  input  logic [TAG_W-1:0] task_tag,
  output logic             task_ready,
  input  logic [N-1:0]     slot_en,
  input  logic [N-1:0]     slot_done,
  output logic [N-1:0]     slot_valid,
  output logic [TAG_W-1:0] slot_tag,
  output logic [N-1:0]     busy,
  output logic             err_done
`ifdef P_DISPATCH_STATS_EN
  ,
  output logic [31:0]      disp_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic {
    S_FREE = 1'b0,
    S_BUSY = 1'b1
  } slot_state_t;

  slot_state_t state [N];

  logic [N-1:0] free;
  logic [N-1:0] target;
  logic         accept;

  // Expose each slot's state as the registered busy vector.
  always_comb begin
    busy = '0;
    for (int i = 0; i < N; i++) begin
      busy[i] = (state[i] == S_BUSY);
    end
  end

  // The done pulse is not bypassed: a slot freed this cycle is allocatable next cycle.
  assign free       = ~busy & slot_en;
  assign task_ready = |free;
  assign accept     = task_valid & task_ready;

  // Pick the lowest-index free slot as a one-hot target.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    target = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        target = '0;
        target[i] = 1'b1;
      end
    end
  end

  // Per-slot FREE/BUSY machines, the dispatch pulse and the sticky done error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= S_FREE;
      end
      slot_valid <= '0;
      slot_tag   <= '0;
      err_done   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case (state[i])
          S_FREE: begin
            if (accept && target[i]) begin
              state[i] <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (slot_done[i]) begin
              state[i] <= S_FREE;
            end
          end
          default: state[i] <= S_FREE;
        endcase
      end
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (|(slot_done & ~busy)) begin
        err_done <= 1'b1;
      end
      if (accept) begin
        slot_valid <= target;
        slot_tag   <= task_tag;
      end else begin
        slot_valid <= '0;
      end
    end
  end

`ifdef P_DISPATCH_STATS_EN
  // Saturating accept and stall counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && disp_cnt != '1) begin
        disp_cnt <= disp_cnt + 32'd1;
      end
      if (task_valid && !task_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_p_dispatch.sv
// Self-checking bench for p_dispatch (N=8, TAG_W=8).
// Directed scenarios are followed by randomized traffic. Every cycle is
// compared against a behavioural model of the slot table.
// Define P_DISPATCH_STATS_EN to also check the statistics counters.
module tb_p_dispatch;

  localparam int N = 8;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             task_valid;
  logic [TAG_W-1:0] task_tag;
  logic             task_ready;
  logic [N-1:0]     slot_en;
  logic [N-1:0]     slot_done;
  logic [N-1:0]     slot_valid;
  logic [TAG_W-1:0] slot_tag;
  logic [N-1:0]     busy;
  logic             err_done;
`ifdef P_DISPATCH_STATS_EN
  logic [31:0]      disp_cnt;
  logic [31:0]      stall_cnt;
`endif

  p_dispatch #(.N(N), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .task_valid (task_valid),
    .task_tag   (task_tag),
    .task_ready (task_ready),
    .slot_en    (slot_en),
    .slot_done  (slot_done),
    .slot_valid (slot_valid),
    .slot_tag   (slot_tag),
    .busy       (busy),
    .err_done   (err_done)
`ifdef P_DISPATCH_STATS_EN
    ,
    .disp_cnt   (disp_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the set of occupied slots plus the expected outputs.
  bit          m_occupied [N];
  bit          m_err;
  int          m_last_slot;   // -1 when nothing was dispatched last cycle
  logic [7:0]  m_tag;
  longint      m_disp;
  longint      m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns the lowest free and enabled slot, or -1 when none exists.
  function automatic int pick_slot(input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      if (!m_occupied[i] && en[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_busy();
    logic [N-1:0] b = '0;
    for (int i = 0; i < N; i++) b[i] = m_occupied[i];
    return b;
  endfunction

  // One clock cycle: drive inputs, check ready, apply the edge, check outputs.
  task automatic step(input logic rst, input logic v, input logic [7:0] tg,
                      input logic [N-1:0] en, input logic [N-1:0] dn);
    int slot;
    bit ready;
    @(negedge clk);
    rst_n = rst; task_valid = v; task_tag = tg; slot_en = en; slot_done = dn;
    #1;
    slot  = pick_slot(en);
    ready = (slot >= 0);
    check("task_ready", {31'd0, task_ready}, {31'd0, ready});
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) m_occupied[i] = 0;
      m_err = 0; m_last_slot = -1; m_tag = '0; m_disp = 0; m_stall = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (dn[i]) begin
          if (m_occupied[i]) m_occupied[i] = 0;
          else m_err = 1;
        end
      end
      if (v && ready) begin
        m_occupied[slot] = 1;
        m_last_slot = slot;
        m_tag = tg;
        if (m_disp < 64'hFFFF_FFFF) m_disp++;
      end else begin
        m_last_slot = -1;
        if (v && m_stall < 64'hFFFF_FFFF) m_stall++;
      end
    end
    #1;
    check("slot_valid", {24'd0, slot_valid},
          (m_last_slot < 0) ? 32'd0 : (32'd1 << m_last_slot));
    check("slot_tag", {24'd0, slot_tag}, {24'd0, m_tag});
    check("busy", {24'd0, busy}, {24'd0, model_busy()});
    check("err_done", {31'd0, err_done}, {31'd0, m_err});
`ifdef P_DISPATCH_STATS_EN
    check("disp_cnt", disp_cnt, m_disp[31:0]);
    check("stall_cnt", stall_cnt, m_stall[31:0]);
`endif
  endtask

  initial begin
    logic [N-1:0] en;
    logic [N-1:0] dn;
    logic [7:0]   tg;
    logic         v;
    rst_n = 1'b0; task_valid = 1'b0; task_tag = '0; slot_en = '0; slot_done = '0;
    for (int i = 0; i < N; i++) m_occupied[i] = 0;
    m_err = 0; m_last_slot = -1; m_tag = '0; m_disp = 0; m_stall = 0;

    // Reset state, then a single task lands in slot 0.
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    check("reset_busy", {24'd0, busy}, 32'h0);
    step(1'b1, 1'b1, 8'h3C, 8'hFF, 8'h00);
    check("first_valid", {24'd0, slot_valid}, 32'h01);
    check("first_tag", {24'd0, slot_tag}, 32'h3C);

    // Eight back-to-back tasks from reset walk slots 0..7, then the table is full.
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'(i), 8'hFF, 8'h00);
      check("walk_valid", {24'd0, slot_valid}, 32'd1 << i);
    end
    check("full_busy", {24'd0, busy}, 32'hFF);
    // Full table: the task stalls. Freeing slot 3 does not bypass into this cycle.
    step(1'b1, 1'b1, 8'hA5, 8'hFF, 8'h08);
    check("stall_no_dispatch", {24'd0, slot_valid}, 32'h00);
    step(1'b1, 1'b1, 8'hA5, 8'hFF, 8'h00);
    check("refill_slot3", {24'd0, slot_valid}, 32'h08);
    check("refill_tag", {24'd0, slot_tag}, 32'hA5);

    // Enable mask excludes slots 0..3.
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    step(1'b1, 1'b1, 8'h11, 8'hF0, 8'h00);
    check("masked_slot4", {24'd0, slot_valid}, 32'h10);

    // A spurious done sets the sticky error without touching busy.
    step(1'b1, 1'b0, 8'h00, 8'hF0, 8'h02);
    check("err_set", {31'd0, err_done}, 32'd1);
    step(1'b1, 1'b0, 8'h00, 8'hF0, 8'h00);
    check("err_sticky", {31'd0, err_done}, 32'd1);

    // Reset in the same cycle as an accept drops the dispatch.
    step(1'b0, 1'b1, 8'h77, 8'hFF, 8'h00);
    check("rst_drop_valid", {24'd0, slot_valid}, 32'h0);
    check("rst_err_clear", {31'd0, err_done}, 32'd0);

`ifdef P_DISPATCH_STATS_EN
    // Three accepts plus two stalled cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(i), 8'h07, 8'h00);
    step(1'b1, 1'b1, 8'h09, 8'h07, 8'h00);
    step(1'b1, 1'b1, 8'h09, 8'h07, 8'h00);
    check("stats_disp", disp_cnt, 32'd3);
    check("stats_stall", stall_cnt, 32'd2);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
`endif

    // Randomized traffic: mostly legal completions, rare spurious ones and resets.
    tg = 8'h00;
    for (int c = 0; c < 600; c++) begin
      en = 8'($urandom_range(0, 3) == 0 ? $urandom : 32'hFF);
      dn = '0;
      for (int i = 0; i < N; i++) begin
        if (m_occupied[i] && $urandom_range(0, 2) == 0) dn[i] = 1'b1;
      end
      if ($urandom_range(0, 60) == 0) dn[$urandom_range(0, N - 1)] = 1'b1;
      v = ($urandom_range(0, 3) != 0);
      // The upstream holds its tag while stalled.
      if (pick_slot(en) >= 0 || !task_valid) tg = 8'($urandom);
      step(($urandom_range(0, 150) != 0), v, tg, en, dn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
